// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencer: widths, opcodes, FSM states and
// the sign-magnitude helper used by the MUL/DIV engine.
package alu_pkg;

    localparam int OPW   = 8;
    localparam int RESW  = 16;
    localparam int ITERS = 8;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_MUL  = 3'd2;
    localparam logic [2:0] OP_DIV  = 3'd3;
    localparam logic [2:0] OP_AND  = 3'd4;
    localparam logic [2:0] OP_OR   = 3'd5;
    localparam logic [2:0] OP_XOR  = 3'd6;
    localparam logic [2:0] OP_NAND = 3'd7;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_e;

    // Magnitude of a two's-complement byte; -128 maps to 8'h80 (unsigned 128).
    function automatic logic [OPW-1:0] mag8(input logic [OPW-1:0] x);
        return x[OPW-1] ? (~x) + OPW'(1) : x;
    endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Request/result handshake bundle between the two requesters, the result
// consumer and alu_sequencer.
interface alu_sequencer_if;
    import alu_pkg::*;

    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [2*OPW-1:0] req_a;
    logic [2*OPW-1:0] req_b;
    logic [5:0]       req_op;
    logic             res_valid;
    logic             res_ready;
    logic [RESW-1:0]  res_data;
    logic             res_id;
    logic             res_err;
    logic             busy;

    modport slave (
        input  req_valid, req_a, req_b, req_op, res_ready,
        output req_ready, res_valid, res_data, res_id, res_err, busy
    );

    modport master (
        output req_valid, req_a, req_b, req_op, res_ready,
        input  req_ready, res_valid, res_data, res_id, res_err, busy
    );

endinterface

// File: rtl/alu_seq_muldiv.sv
// 8-iteration shift-add multiplier and restoring divider on operand magnitudes.
// The divider is only built when ALU_SEQ_DIV_EN is defined.
module alu_seq_muldiv
    import alu_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic [2:0]      op_i,
    input  logic [OPW-1:0]  a_i,
    input  logic [OPW-1:0]  b_i,
    output logic            done_o,
    output logic [RESW-1:0] result_o
);

    localparam logic [3:0] LAST = 4'(ITERS - 1);

    logic            run_q,   run_d;
    logic            neg_q,   neg_d;
    logic [3:0]      cnt_q,   cnt_d;
    logic [RESW-1:0] acc_q,   acc_d;    // product, or remainder in [7:0]
    logic [RESW-1:0] mcand_q, mcand_d;  // shifted multiplicand, or divisor in [7:0]
    logic [OPW-1:0]  shreg_q, shreg_d;  // multiplier bits, or dividend/quotient
    logic [RESW-1:0] mag;
    logic            start_ok;
`ifdef ALU_SEQ_DIV_EN
    logic            is_div_q, is_div_d;
    logic [OPW:0]    rem_sh;

    assign start_ok = start_i;
`else
    assign start_ok = start_i && (op_i == OP_MUL);
`endif

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
        run_d   = run_q;
        neg_d   = neg_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        mcand_d = mcand_q;
        shreg_d = shreg_q;
`ifdef ALU_SEQ_DIV_EN
        is_div_d = is_div_q;
        rem_sh   = '0;
`endif
        if (start_ok) begin
            run_d   = 1'b1;
            neg_d   = a_i[OPW-1] ^ b_i[OPW-1];
            cnt_d   = '0;
            acc_d   = '0;
            mcand_d = {{OPW{1'b0}}, mag8(a_i)};
            shreg_d = mag8(b_i);
`ifdef ALU_SEQ_DIV_EN
            is_div_d = (op_i == OP_DIV);
            if (is_div_d) begin
                mcand_d = {{OPW{1'b0}}, mag8(b_i)};
                shreg_d = mag8(a_i);
            end
`endif
        end else if (run_q) begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == LAST) run_d = 1'b0;
`ifdef ALU_SEQ_DIV_EN
            if (is_div_q) begin
                // Dividend bits leave shreg at the top while quotient bits enter at the bottom.
                rem_sh = {acc_q[OPW-1:0], shreg_q[OPW-1]};
                if (rem_sh >= {1'b0, mcand_q[OPW-1:0]}) begin
                    acc_d   = {{(RESW-OPW-1){1'b0}}, rem_sh - {1'b0, mcand_q[OPW-1:0]}};
                    shreg_d = {shreg_q[OPW-2:0], 1'b1};
                end else begin
                    acc_d   = {{(RESW-OPW-1){1'b0}}, rem_sh};
                    shreg_d = {shreg_q[OPW-2:0], 1'b0};
                end
            end else begin
                acc_d   = acc_q + (shreg_q[0] ? mcand_q : '0);
                mcand_d = mcand_q << 1;
                shreg_d = shreg_q >> 1;
            end
`else
            acc_d   = acc_q + (shreg_q[0] ? mcand_q : '0);
            mcand_d = mcand_q << 1;
            shreg_d = shreg_q >> 1;
`endif
        end
    end

    // Result is taken from the next-state values so the last iteration is included.
`ifdef ALU_SEQ_DIV_EN
    assign mag = is_div_q ? {{OPW{1'b0}}, shreg_d} : acc_d;
`else
    assign mag = acc_d;
`endif
    assign result_o = neg_q ? -mag : mag;
    assign done_o   = run_q && (cnt_q == LAST);

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_q   <= 1'b0;
            neg_q   <= 1'b0;
            cnt_q   <= '0;
            acc_q   <= '0;
            mcand_q <= '0;
            shreg_q <= '0;
`ifdef ALU_SEQ_DIV_EN
            is_div_q <= 1'b0;
`endif
        end else begin
            run_q   <= run_d;
            neg_q   <= neg_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            mcand_q <= mcand_d;
            shreg_q <= shreg_d;
`ifdef ALU_SEQ_DIV_EN
            is_div_q <= is_div_d;
`endif
        end
    end

endmodule

// File: rtl/alu_sequencer.sv
// Two-port round-robin ALU sequencer: 1-cycle ADD/SUB/logic, 8-iteration MUL/DIV.
// ALU_SEQ_DIV_EN builds the divider; without it DIV returns 0 with res_err set.
module alu_sequencer
    import alu_pkg::*;
(
    input  logic           CLOCK_50,
    input  logic           rst,
    alu_sequencer_if.slave bus
);

    state_e          state_q, state_d;
    logic            last_grant_q, last_grant_d;
    logic [RESW-1:0] res_data_q, res_data_d;
    logic            res_id_q, res_id_d;
    logic            res_err_q, res_err_d;

    logic            grant_any, grant_idx, accept;
    logic [OPW-1:0]  sel_a, sel_b, alu8;
    logic [2:0]      sel_op;
    logic            alu_sext, div_err, needs_exec;
    logic [RESW-1:0] alu_res, md_result;
    logic            md_done;

    // Both pending: the requester not granted last time wins.
    assign grant_any = |bus.req_valid;
    assign grant_idx = (&bus.req_valid) ? ~last_grant_q : ~bus.req_valid[0];
    assign accept    = (state_q == IDLE) && grant_any;

    assign sel_a  = grant_idx ? bus.req_a[15:8] : bus.req_a[7:0];
    assign sel_b  = grant_idx ? bus.req_b[15:8] : bus.req_b[7:0];
    assign sel_op = grant_idx ? bus.req_op[5:3] : bus.req_op[2:0];

`ifdef ALU_SEQ_DIV_EN
    assign div_err    = (sel_op == OP_DIV) && (sel_b == '0);
    assign needs_exec = (sel_op == OP_MUL) || ((sel_op == OP_DIV) && !div_err);
`else
    assign div_err    = (sel_op == OP_DIV);
    assign needs_exec = (sel_op == OP_MUL);
`endif

    always_comb begin
        alu8     = '0;
        alu_sext = 1'b0;
        case (sel_op)
            OP_ADD:  begin alu8 = sel_a + sel_b; alu_sext = 1'b1; end
            OP_SUB:  begin alu8 = sel_a - sel_b; alu_sext = 1'b1; end
            OP_AND:  alu8 = sel_a & sel_b;
            OP_OR:   alu8 = sel_a | sel_b;
            OP_XOR:  alu8 = sel_a ^ sel_b;
            OP_NAND: alu8 = ~(sel_a & sel_b);
            default: alu8 = '0;
        endcase
        alu_res = alu_sext ? {{OPW{alu8[OPW-1]}}, alu8} : {{OPW{1'b0}}, alu8};
    end

    alu_seq_muldiv u_muldiv (
        .clk      (CLOCK_50),
        .rst      (rst),
        .start_i  (accept && needs_exec),
        .op_i     (sel_op),
        .a_i      (sel_a),
        .b_i      (sel_b),
        .done_o   (md_done),
        .result_o (md_result)
    );

    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = needs_exec ? EXEC : DONE;
            EXEC:    if (md_done) state_d = DONE;
            DONE:    if (bus.res_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready = '0;
        if (accept && !rst) bus.req_ready = grant_idx ? 2'b10 : 2'b01;
        bus.res_valid = (state_q == DONE);
        bus.busy      = (state_q != IDLE);
        bus.res_data  = res_data_q;
        bus.res_id    = res_id_q;
        bus.res_err   = res_err_q;
    end

    // Result registers load at accept (single-cycle ops) or on engine completion.
    always_comb begin
        last_grant_d = last_grant_q;
        res_data_d   = res_data_q;
        res_id_d     = res_id_q;
        res_err_d    = res_err_q;
        if (accept) begin
            last_grant_d = grant_idx;
            res_id_d     = grant_idx;
            if (!needs_exec) begin
                res_data_d = alu_res;
                res_err_d  = div_err;
            end
        end else if ((state_q == EXEC) && md_done) begin
            res_data_d = md_result;
            res_err_d  = 1'b0;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            last_grant_q <= 1'b1;
            res_data_q   <= '0;
            res_id_q     <= 1'b0;
            res_err_q    <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            res_data_q   <= res_data_d;
            res_id_q     <= res_id_d;
            res_err_q    <= res_err_d;
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed self-checking bench for alu_sequencer; DIV vectors follow ALU_SEQ_DIV_EN.
module tb_alu_sequencer;
    import alu_pkg::*;

    logic CLOCK_50 = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    alu_sequencer_if bus ();

    alu_sequencer dut (
        .CLOCK_50 (CLOCK_50),
        .rst      (rst),
        .bus      (bus)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic set_req(input int id, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        if (id == 0) begin
            bus.req_op[2:0] = op; bus.req_a[7:0] = a; bus.req_b[7:0] = b;
        end else begin
            bus.req_op[5:3] = op; bus.req_a[15:8] = a; bus.req_b[15:8] = b;
        end
        bus.req_valid[id] = 1'b1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        bus.req_valid = '0;
        bus.res_ready = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic drain();
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
    endtask

    // Issues one request and waits (bounded) for its result; leaves the DUT in DONE.
    task automatic do_op(input int id, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                         output logic [15:0] data, output logic rid, output logic err,
                         output int lat, output logic busy_ok, output logic ok);
        int n;
        data = '0; rid = 1'b0; err = 1'b0; lat = 0; busy_ok = 1'b0; ok = 1'b0;
        set_req(id, op, a, b);
        #1;
        n = 0;
        while (bus.req_ready[id] !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        if (bus.req_ready[id] === 1'b1) begin
            tick();
            bus.req_valid[id] = 1'b0;
            lat = 1;
            busy_ok = 1'b1;
            while (bus.res_valid !== 1'b1 && lat < 40) begin
                if (bus.busy !== 1'b1) busy_ok = 1'b0;
                tick();
                lat++;
            end
            if (bus.busy !== 1'b1) busy_ok = 1'b0;
            ok   = (bus.res_valid === 1'b1);
            data = bus.res_data;
            rid  = bus.res_id;
            err  = bus.res_err;
        end else begin
            bus.req_valid[id] = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req_valid = 2'b11;
        repeat (2) tick();
        n_checks++; if (bus.req_ready !== 2'b00) begin n_fail++; $display("FAIL reset req_ready: got %b required 00", bus.req_ready); end
        n_checks++; if (bus.res_valid !== 1'b0) begin n_fail++; $display("FAIL reset res_valid: got %b required 0", bus.res_valid); end
        n_checks++; if (bus.res_data !== 16'h0000) begin n_fail++; $display("FAIL reset res_data: got %h required 0000", bus.res_data); end
        n_checks++; if (bus.res_id !== 1'b0) begin n_fail++; $display("FAIL reset res_id: got %b required 0", bus.res_id); end
        n_checks++; if (bus.res_err !== 1'b0) begin n_fail++; $display("FAIL reset res_err: got %b required 0", bus.res_err); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset busy: got %b required 0", bus.busy); end
        bus.req_valid = '0;
        rst = 1'b0;
        tick();
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset idle busy: got %b required 0", bus.busy); end
    endtask

    task automatic test_add_sub();
        int         vid [8];
        logic [2:0] vop [8];
        logic [7:0] va  [8];
        logic [7:0] vb  [8];
        logic [15:0] ve [8];
        logic [15:0] data; logic rid, err, busy_ok, ok; int lat;
        vid = '{0, 0, 0, 1, 0, 1, 1, 0};
        vop = '{OP_ADD, OP_ADD, OP_SUB, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NAND};
        va  = '{8'd100, 8'd127, 8'd0, 8'h80, 8'hF0, 8'hF0, 8'hAA, 8'hF0};
        vb  = '{8'd27, 8'd1, 8'd1, 8'd1, 8'h3C, 8'h0F, 8'h0F, 8'h3C};
        ve  = '{16'h007F, 16'hFF80, 16'hFFFF, 16'h007F, 16'h0030, 16'h00FF, 16'h00A5, 16'h00CF};
        for (int i = 0; i < 8; i++) begin
            do_op(vid[i], vop[i], va[i], vb[i], data, rid, err, lat, busy_ok, ok);
            n_checks++; if (!ok || data !== ve[i]) begin n_fail++; $display("FAIL add_sub[%0d] data: got %h required %h (done=%b)", i, data, ve[i], ok); end
            n_checks++; if (rid !== vid[i][0]) begin n_fail++; $display("FAIL add_sub[%0d] res_id: got %b required %0d", i, rid, vid[i]); end
            n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL add_sub[%0d] res_err: got %b required 0", i, err); end
            n_checks++; if (lat != 1) begin n_fail++; $display("FAIL add_sub[%0d] latency: got %0d required 1", i, lat); end
            drain();
        end
    endtask

    task automatic test_mul();
        int         vid [4];
        logic [7:0] va  [4];
        logic [7:0] vb  [4];
        logic [15:0] ve [4];
        logic [15:0] data; logic rid, err, busy_ok, ok; int lat;
        vid = '{0, 1, 0, 1};
        va  = '{8'h80, 8'd7, 8'd12, 8'hFF};
        vb  = '{8'h80, 8'hFD, 8'd11, 8'hFF};
        ve  = '{16'h4000, 16'hFFEB, 16'h0084, 16'h0001};
        for (int i = 0; i < 4; i++) begin
            do_op(vid[i], OP_MUL, va[i], vb[i], data, rid, err, lat, busy_ok, ok);
            n_checks++; if (!ok || data !== ve[i]) begin n_fail++; $display("FAIL mul[%0d] data: got %h required %h (done=%b)", i, data, ve[i], ok); end
            n_checks++; if (rid !== vid[i][0] || err !== 1'b0) begin n_fail++; $display("FAIL mul[%0d] id/err: got %b/%b required %0d/0", i, rid, err, vid[i]); end
            n_checks++; if (lat != 9) begin n_fail++; $display("FAIL mul[%0d] latency: got %0d required 9", i, lat); end
            n_checks++; if (busy_ok !== 1'b1) begin n_fail++; $display("FAIL mul[%0d] busy: got low during op, required high", i); end
            drain();
        end
    endtask

    task automatic test_div();
        logic [7:0]  va  [4];
        logic [7:0]  vb  [4];
        logic [15:0] ve  [4];
        logic        vr  [4];
        int          vl  [4];
        int          nvec;
        logic [15:0] data; logic rid, err, busy_ok, ok; int lat;
`ifdef ALU_SEQ_DIV_EN
        nvec = 4;
        va = '{8'hF9, 8'h80, 8'd5, 8'd100};
        vb = '{8'd2, 8'hFF, 8'd0, 8'hF9};
        ve = '{16'hFFFD, 16'h0080, 16'h0000, 16'hFFF2};
        vr = '{1'b0, 1'b0, 1'b1, 1'b0};
        vl = '{9, 9, 1, 9};
`else
        nvec = 2;
        va = '{8'hF9, 8'd5, 8'd0, 8'd0};
        vb = '{8'd2, 8'd0, 8'd0, 8'd0};
        ve = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};
        vr = '{1'b1, 1'b1, 1'b0, 1'b0};
        vl = '{1, 1, 0, 0};
`endif
        for (int i = 0; i < nvec; i++) begin
            do_op(i % 2, OP_DIV, va[i], vb[i], data, rid, err, lat, busy_ok, ok);
            n_checks++; if (!ok || data !== ve[i]) begin n_fail++; $display("FAIL div[%0d] data: got %h required %h (done=%b)", i, data, ve[i], ok); end
            n_checks++; if (err !== vr[i]) begin n_fail++; $display("FAIL div[%0d] res_err: got %b required %b", i, err, vr[i]); end
            n_checks++; if (lat != vl[i]) begin n_fail++; $display("FAIL div[%0d] latency: got %0d required %0d", i, lat, vl[i]); end
            drain();
        end
    endtask

    task automatic test_arbitration();
        logic [1:0]  exp_rdy;
        logic [15:0] exp_d;
        apply_reset();
        set_req(0, OP_ADD, 8'd1, 8'd1);
        set_req(1, OP_ADD, 8'd2, 8'd3);
        bus.res_ready = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            exp_rdy = (k % 2 == 0) ? 2'b01 : 2'b10;
            exp_d   = (k % 2 == 0) ? 16'h0002 : 16'h0005;
            n_checks++; if (bus.req_ready !== exp_rdy) begin n_fail++; $display("FAIL arb[%0d] grant: got %b required %b", k, bus.req_ready, exp_rdy); end
            tick();
            n_checks++; if (bus.res_valid !== 1'b1 || bus.res_id !== exp_rdy[1]) begin n_fail++; $display("FAIL arb[%0d] res_id: got %b (valid %b) required %b", k, bus.res_id, bus.res_valid, exp_rdy[1]); end
            n_checks++; if (bus.res_data !== exp_d) begin n_fail++; $display("FAIL arb[%0d] data: got %h required %h", k, bus.res_data, exp_d); end
            tick();
        end
        bus.req_valid = '0;
        bus.res_ready = 1'b0;
        tick();
    endtask

    task automatic test_back_pressure();
        logic [15:0] data; logic rid, err, busy_ok, ok; int lat;
        do_op(0, OP_ADD, 8'd3, 8'd4, data, rid, err, lat, busy_ok, ok);
        n_checks++; if (!ok || data !== 16'h0007) begin n_fail++; $display("FAIL bp first data: got %h required 0007 (done=%b)", data, ok); end
        set_req(1, OP_XOR, 8'h55, 8'h0F);
        for (int k = 0; k < 5; k++) begin
            tick();
            n_checks++; if (bus.res_valid !== 1'b1 || bus.res_data !== 16'h0007 || bus.res_id !== 1'b0) begin
                n_fail++; $display("FAIL bp hold[%0d]: got valid %b data %h id %b required 1 0007 0", k, bus.res_valid, bus.res_data, bus.res_id); end
            n_checks++; if (bus.req_ready !== 2'b00) begin n_fail++; $display("FAIL bp hold[%0d] req_ready: got %b required 00", k, bus.req_ready); end
        end
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        n_checks++; if (bus.res_valid !== 1'b0 || bus.req_ready !== 2'b10) begin n_fail++; $display("FAIL bp release: got valid %b req_ready %b required 0 10", bus.res_valid, bus.req_ready); end
        tick();
        bus.req_valid[1] = 1'b0;
        n_checks++; if (bus.res_valid !== 1'b1 || bus.res_id !== 1'b1 || bus.res_data !== 16'h005A) begin
            n_fail++; $display("FAIL bp next: got valid %b id %b data %h required 1 1 005A", bus.res_valid, bus.res_id, bus.res_data); end
        drain();
    endtask

    task automatic test_reset_mid_op();
        int stale;
        set_req(0, OP_MUL, 8'd7, 8'hFD);
        #1;
        n_checks++; if (bus.req_ready !== 2'b01) begin n_fail++; $display("FAIL rst_mid grant: got %b required 01", bus.req_ready); end
        tick();
        bus.req_valid = '0;
        repeat (4) tick();
        n_checks++; if (bus.busy !== 1'b1 || bus.res_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid exec: got busy %b valid %b required 1 0", bus.busy, bus.res_valid); end
        #2;
        rst = 1'b1;
        #1;
        n_checks++; if (bus.busy !== 1'b0 || bus.res_valid !== 1'b0 || bus.req_ready !== 2'b00) begin
            n_fail++; $display("FAIL rst_mid async ctrl: got busy %b valid %b req_ready %b required 0 0 00", bus.busy, bus.res_valid, bus.req_ready); end
        n_checks++; if (bus.res_data !== 16'h0000 || bus.res_id !== 1'b0 || bus.res_err !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid async data: got data %h id %b err %b required 0000 0 0", bus.res_data, bus.res_id, bus.res_err); end
        repeat (2) tick();
        rst = 1'b0;
        stale = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0) stale++;
        end
        n_checks++; if (stale != 0) begin n_fail++; $display("FAIL rst_mid stale: got %0d cycles with valid/busy high required 0", stale); end
        set_req(0, OP_ADD, 8'd9, 8'd9);
        set_req(1, OP_ADD, 8'd1, 8'd1);
        #1;
        n_checks++; if (bus.req_ready !== 2'b01) begin n_fail++; $display("FAIL rst_mid first grant: got %b required 01", bus.req_ready); end
        tick();
        bus.req_valid = '0;
        n_checks++; if (bus.res_valid !== 1'b1 || bus.res_id !== 1'b0 || bus.res_data !== 16'h0012) begin
            n_fail++; $display("FAIL rst_mid first result: got valid %b id %b data %h required 1 0 0012", bus.res_valid, bus.res_id, bus.res_data); end
        drain();
    endtask

    initial begin
        rst           = 1'b1;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_op    = '0;
        bus.res_ready = 1'b0;
        test_reset();
        test_add_sub();
        test_mul();
        test_div();
        test_arbitration();
        test_back_pressure();
        test_reset_mid_op();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
